mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit 4:1 word multiplexer among four requesters.
- Each cycle it picks one pending requester and drives that requester's index onto the mux select.
- It captures the selected word into an output register and presents it downstream with a valid/ready handshake.
- Sits between four producer blocks and a single consumer, such as a register-file write port or a display bus.

---
 rtl/mux4_rr_arbiter.sv | 87 ++++++++
 tb/tb_mux4_rr_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux among four requesters,
// with a registered output word and a valid/ready handshake downstream.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       dout_src,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  logic [1:0]       last;
  logic [1:0]       winner;
  logic             found;
  logic             load_ok;
  logic             grant;
  logic [WIDTH-1:0] mux_out;

  assign load_ok = ~dout_valid | dout_ready;

  // Search last+1 .. last+4 (mod 4) so the previous winner ranks lowest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      logic [1:0] idx;
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant = ~rst & load_ok & found;

  always_comb begin
    gnt = '0;
    sel = '0;
    if (grant) begin
      gnt[winner] = 1'b1;
      sel         = winner;
    end
  end

  always_comb begin
    mux_out = '0;
    case (sel)
      2'd0: mux_out = din0;
      2'd1: mux_out = din1;
      2'd2: mux_out = din2;
      2'd3: mux_out = din3;
      default: mux_out = '0;
    endcase
  end

  // With load_ok and no winner the word was either consumed or never valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_src   <= '0;
      dout_valid <= 1'b0;
      last       <= 2'd3;
    end else if (grant) begin
      dout       <= mux_out;
      dout_src   <= sel;
      dout_valid <= 1'b1;
      last       <= sel;
    end else if (load_ok) begin
      dout_valid <= 1'b0;
    end
  end

  assign busy = dout_valid | (|req);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din0, din1, din2, din3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] dout;
  logic [1:0]  dout_src;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.WIDTH(32), .N_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_src   (dout_src),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_word [4];
    rst = 1'b1; req = 4'b1111; dout_ready = 1'b1;
    din0 = 32'h0000_0000; din1 = 32'h1111_1111;
    din2 = 32'h2222_2222; din3 = 32'h3333_3333;
    exp_word[0] = 32'h0000_0000; exp_word[1] = 32'h1111_1111;
    exp_word[2] = 32'h2222_2222; exp_word[3] = 32'h3333_3333;

    // Reset for two cycles
    step(); step();
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_sel",   32'(sel), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_dout",  dout, 32'h0);
    chk("rst_src",   32'(dout_src), 32'h0);
    chk("rst_busy",  32'(busy), 32'h1);

    rst = 1'b0;
    #1;
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_sel", 32'(sel), 32'h0);

    // Round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      step();
      chk("rr_src",   32'(dout_src), 32'(k % 4));
      chk("rr_dout",  dout, exp_word[k % 4]);
      chk("rr_valid", 32'(dout_valid), 32'h1);
    end

    // Load DEADBEEF from requester 0 (last=0, only req0 pending)
    req = 4'b0001; din0 = 32'hDEAD_BEEF;
    #1;
    chk("bp_load_gnt", 32'(gnt), 32'h1);
    step();
    chk("bp_load_dout", dout, 32'hDEAD_BEEF);

    // Backpressure for 5 cycles
    req = 4'b0110; dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_gnt", 32'(gnt), 32'h0);
      chk("bp_sel", 32'(sel), 32'h0);
      step();
      chk("bp_dout",  dout, 32'hDEAD_BEEF);
      chk("bp_valid", 32'(dout_valid), 32'h1);
      chk("bp_src",   32'(dout_src), 32'h0);
    end
    dout_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(gnt), 32'h2);
    chk("bp_release_sel", 32'(sel), 32'h1);
    step();
    chk("bp_release_dout", dout, 32'h1111_1111);
    chk("bp_release_src",  32'(dout_src), 32'h1);

    // Pointer skip: last=1, req=1001 -> 3 then 0
    req = 4'b1001;
    #1;
    chk("skip_gnt3", 32'(gnt), 32'h8);
    chk("skip_sel3", 32'(sel), 32'h3);
    step();
    chk("skip_dout3", dout, 32'h3333_3333);
    chk("skip_gnt0", 32'(gnt), 32'h1);
    step();
    chk("skip_src0",  32'(dout_src), 32'h0);
    chk("skip_dout0", dout, 32'hDEAD_BEEF);

    // Drain: single req[2] pulse
    req = 4'b0100; din2 = 32'hA5A5_A5A5;
    #1;
    chk("drain_gnt", 32'(gnt), 32'h4);
    step();
    req = 4'b0000;
    #1;
    chk("drain_valid1", 32'(dout_valid), 32'h1);
    chk("drain_dout",   dout, 32'hA5A5_A5A5);
    chk("drain_src",    32'(dout_src), 32'h2);
    chk("drain_busy1",  32'(busy), 32'h1);
    chk("drain_gnt0",   32'(gnt), 32'h0);
    step();
    chk("drain_valid0", 32'(dout_valid), 32'h0);
    chk("drain_busy0",  32'(busy), 32'h0);
    chk("drain_hold",   dout, 32'hA5A5_A5A5);

    // Reset mid-stall; load from requester 2 so last=2 before reset
    req = 4'b0100; din2 = 32'h5A5A_5A5A;
    #1;
    chk("rs_pre_gnt", 32'(gnt), 32'h4);
    step();
    req = 4'b0000; dout_ready = 1'b0;
    step();
    chk("rs_stall_valid", 32'(dout_valid), 32'h1);
    chk("rs_stall_dout",  dout, 32'h5A5A_5A5A);
    rst = 1'b1;
    step();
    chk("rs_valid", 32'(dout_valid), 32'h0);
    chk("rs_dout",  dout, 32'h0);
    rst = 1'b0; req = 4'b1100; dout_ready = 1'b1;
    #1;
    chk("rs_ptr_gnt", 32'(gnt), 32'h4);
    chk("rs_ptr_sel", 32'(sel), 32'h2);
    step();
    chk("rs_ptr_src",  32'(dout_src), 32'h2);
    chk("rs_ptr_dout", dout, 32'h5A5A_5A5A);
    chk("rs_next_gnt", 32'(gnt), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
